// File: rtl/rca_writeback_source.sv
// ---------------------------------------------------------------------------
// rca_writeback_source
//
// Producer end of the RCA writeback path. Results coming out of the RCA
// compute pipeline (one instruction id plus NUM_WRITE_PORTS rd values) are
// queued in a small circular buffer and offered, oldest first, to the
// writeback/commit stage. The consumer retires the head entry with wb_ack.
// Results are never reordered.
//
// Optional feature macro: RCA_WB_BYPASS_EN
//   When defined, an incoming result seen while the buffer is empty is
//   presented on the writeback side in the same cycle. If it is acked in
//   that cycle it never enters the buffer.
//   When undefined, there is no combinational input-to-output path and a
//   result appears on the writeback side one cycle after it is accepted.
//
// Parameters
//   NUM_WRITE_PORTS  rd values carried per result
//   FIFO_DEPTH       buffered entries (power of 2, >= 2)
//   XLEN             width of each rd value
//   ID_W             width of the opaque instruction id
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous reset, active low
//   flush         drops every buffered result (takes priority over push/pop)
//   result_valid  RCA pipeline presents a result
//   result_id     id of the presented result
//   result_data   rd values of the presented result
//   result_ready  buffer can accept a result (not full)
//   wb_id         head entry id (0 when nothing is offered)
//   wb_done       head entry valid
//   wb_rd         head entry rd values (0 when nothing is offered)
//   wb_ack        consumer retires the head entry this cycle
//   occupancy     number of buffered entries
// ---------------------------------------------------------------------------
module rca_writeback_source #(
    parameter int NUM_WRITE_PORTS = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int XLEN            = 32,
    parameter int ID_W            = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic                                    result_valid,
    input  logic [ID_W-1:0]                         result_id,
    input  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]    result_data,
    output logic                                    result_ready,
    output logic [ID_W-1:0]                         wb_id,
    output logic                                    wb_done,
    output logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]    wb_rd,
    input  logic                                    wb_ack,
    output logic [$clog2(FIFO_DEPTH):0]             occupancy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]                      id_mem [FIFO_DEPTH];
    logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] rd_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic buffer_valid;
    logic bypass_hit;
    logic push;
    logic mem_push;
    logic mem_pop;

    // Readiness and head validity are derived from the registered count only,
    // so result_ready never depends on wb_ack: a full buffer refuses a push
    // even in a cycle where the head is being retired.
    assign buffer_valid = (count != '0);
    assign result_ready = (count != CNT_W'(FIFO_DEPTH));
    assign occupancy    = count;

    // The bypass only applies to an empty buffer outside reset/flush. A flush
    // in the same cycle must not show a bypassed result as done.
`ifdef RCA_WB_BYPASS_EN
    assign bypass_hit = rst & ~flush & result_valid & ~buffer_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    assign wb_done = buffer_valid | bypass_hit;
    assign push    = result_valid & result_ready;

    // A bypassed result that is acked in the same cycle is consumed directly
    // and never written. Pops only ever come from the buffer, since a bypass
    // can only occur while the buffer is empty.
    assign mem_push = push & ~(bypass_hit & wb_ack);
    assign mem_pop  = buffer_valid & wb_ack;

    // Head presentation: the buffered head wins, then a bypassed input, and
    // otherwise the outputs are masked to zero so stale storage never leaks.
    always_comb begin
        wb_id = '0;
        wb_rd = '0;
        if (buffer_valid) begin
            wb_id = id_mem[rd_ptr];
            wb_rd = rd_mem[rd_ptr];
        end else if (bypass_hit) begin
            wb_id = result_id;
            wb_rd = result_data;
        end
    end

    // Pointer and count bookkeeping. Reset and flush behave identically:
    // everything buffered is dropped and any push/pop in that cycle is ignored.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (mem_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (mem_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(mem_push) - CNT_W'(mem_pop);
        end
    end

    // Result storage needs no reset: entries are only ever read while the
    // count says they hold data.
    always_ff @(posedge clk) begin
        if (rst && !flush && mem_push) begin
            id_mem[wr_ptr] <= result_id;
            rd_mem[wr_ptr] <= result_data;
        end
    end

    // An ack with nothing on offer is harmless (it is simply ignored) but it
    // usually points at a consumer bug, so it is reported as a warning.
    always @(posedge clk) begin
        if (rst && !flush) begin
            assert (!(wb_ack && !wb_done))
            else $warning("rca_writeback_source: wb_ack seen with no result offered");
        end
    end

endmodule

// File: tb/tb_rca_writeback_source.sv
// ---------------------------------------------------------------------------
// tb_rca_writeback_source
//
// Directed bench for rca_writeback_source. A queue-based reference model
// tracks which results should be buffered; every cycle the DUT outputs are
// compared against it, and hand-computed expectations pin key scenarios
// (reset, single result, fill/refuse, wrap, flush, spurious ack, reset
// mid-operation). Honours RCA_WB_BYPASS_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_rca_writeback_source;

    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0]  id;
        logic [63:0] rd;
    } entry_t;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             result_valid;
    logic [7:0]       result_id;
    logic [1:0][31:0] result_data;
    logic             result_ready;
    logic [7:0]       wb_id;
    logic             wb_done;
    logic [1:0][31:0] wb_rd;
    logic             wb_ack;
    logic [2:0]       occupancy;

    int     check_count;
    int     pass_count;
    logic   check_en;
    logic   track_occ;
    int     max_occ;
    entry_t model[$];
    logic [7:0] retired[$];

    rca_writeback_source #(
        .NUM_WRITE_PORTS(2),
        .FIFO_DEPTH(DEPTH),
        .XLEN(32),
        .ID_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .result_valid(result_valid),
        .result_id(result_id),
        .result_data(result_data),
        .result_ready(result_ready),
        .wb_id(wb_id),
        .wb_done(wb_done),
        .wb_rd(wb_rd),
        .wb_ack(wb_ack),
        .occupancy(occupancy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] mkRd(input int id);
        return {32'hA000_0000 | 32'(id), 32'hB000_0000 | 32'(id)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end else begin
            pass_count++;
        end
    endtask

    // Drive one cycle of inputs, let the rising edge happen, then return
    // just after it so the caller sees the updated state.
    task automatic applyStimulus(input logic v, input int id, input logic [63:0] rd,
                                 input logic ack, input logic fl);
        result_valid = v;
        result_id    = 8'(id);
        result_data  = rd;
        wb_ack       = ack;
        flush        = fl;
        @(posedge clk);
        #1;
    endtask

    // Reference model update: a plain FIFO of results. Reset or flush empties
    // it; otherwise the head leaves on an ack and a new result joins when
    // there was room at the start of the cycle.
    always @(posedge clk) begin
        int     sz;
        logic   byp;
        logic   offered;
        entry_t e;
        if (!rst || flush) begin
            model.delete();
        end else begin
            sz  = model.size();
            byp = 1'b0;
`ifdef RCA_WB_BYPASS_EN
            byp = result_valid && (sz == 0);
`endif
            offered = (sz > 0) || byp;
            e.id = result_id;
            e.rd = result_data;
            if (!(byp && wb_ack)) begin
                if (offered && wb_ack && sz > 0) begin
                    void'(model.pop_front());
                end
                if (result_valid && sz != DEPTH) begin
                    model.push_back(e);
                end
            end
        end
    end

    // Record which ids the consumer actually retired.
    always @(posedge clk) begin
        if (rst && !flush && wb_done && wb_ack) begin
            retired.push_back(wb_id);
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        logic        exp_done;
        logic [7:0]  exp_id;
        logic [63:0] exp_rd;
        logic        byp;
        if (check_en) begin
            byp = 1'b0;
`ifdef RCA_WB_BYPASS_EN
            byp = rst && !flush && result_valid && (model.size() == 0);
`endif
            exp_done = 1'b0;
            exp_id   = '0;
            exp_rd   = '0;
            if (model.size() > 0) begin
                exp_done = 1'b1;
                exp_id   = model[0].id;
                exp_rd   = model[0].rd;
            end else if (byp) begin
                exp_done = 1'b1;
                exp_id   = result_id;
                exp_rd   = result_data;
            end
            checkOutput("model_done", 64'(wb_done), 64'(exp_done));
            checkOutput("model_id", 64'(wb_id), 64'(exp_id));
            checkOutput("model_rd", wb_rd, exp_rd);
            checkOutput("model_ready", 64'(result_ready), 64'(model.size() != DEPTH));
            checkOutput("model_occupancy", 64'(occupancy), 64'(model.size()));
            if (track_occ && int'(occupancy) > max_occ) begin
                max_occ = int'(occupancy);
            end
        end
    end

    initial begin
        check_count = 0;
        pass_count  = 0;
        check_en    = 1'b0;
        track_occ   = 1'b0;
        max_occ     = 0;
        rst         = 1'b0;

        // Reset held for two cycles while a result is presented.
        applyStimulus(1, 9, mkRd(9), 0, 0);
        check_en = 1'b1;
        applyStimulus(1, 9, mkRd(9), 0, 0);
        checkOutput("reset_done", 64'(wb_done), 64'd0);
        checkOutput("reset_ready", 64'(result_ready), 64'd1);
        checkOutput("reset_occupancy", 64'(occupancy), 64'd0);
        checkOutput("reset_id", 64'(wb_id), 64'd0);
        rst = 1'b1;

        // Single result with ack held high.
        retired.delete();
        applyStimulus(1, 5, {32'hA, 32'hB}, 1, 0);
`ifndef RCA_WB_BYPASS_EN
        checkOutput("single_done", 64'(wb_done), 64'd1);
        checkOutput("single_id", 64'(wb_id), 64'd5);
        checkOutput("single_rd", wb_rd, 64'h0000000A_0000000B);
`endif
        applyStimulus(0, 0, 64'd0, 1, 0);
        checkOutput("single_occupancy_after", 64'(occupancy), 64'd0);
        checkOutput("single_retired_count", 64'(retired.size()), 64'd1);
        if (retired.size() == 1) checkOutput("single_retired_id", 64'(retired[0]), 64'd5);

        // Fill to capacity, refuse a fifth, then a full-cycle pop that still refuses.
        retired.delete();
        for (int i = 1; i <= 4; i++) applyStimulus(1, i, mkRd(i), 0, 0);
        checkOutput("fill_ready", 64'(result_ready), 64'd0);
        checkOutput("fill_occupancy", 64'(occupancy), 64'd4);
        applyStimulus(1, 5, mkRd(5), 0, 0);
        checkOutput("fill_refused_occupancy", 64'(occupancy), 64'd4);
        checkOutput("fill_head_id", 64'(wb_id), 64'd1);
        applyStimulus(1, 6, mkRd(6), 1, 0);
        checkOutput("full_pop_occupancy", 64'(occupancy), 64'd3);
        checkOutput("full_pop_ready", 64'(result_ready), 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 64'd0, 1, 0);
        checkOutput("drain_occupancy", 64'(occupancy), 64'd0);
        checkOutput("drain_retired_count", 64'(retired.size()), 64'd4);
        for (int i = 0; i < retired.size() && i < 4; i++)
            checkOutput("drain_order", 64'(retired[i]), 64'(i + 1));

        // Continuous push and ack across four pointer wraps.
        retired.delete();
        max_occ   = 0;
        track_occ = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(1, i, mkRd(i), 1, 0);
        applyStimulus(0, 0, 64'd0, 1, 0);
        applyStimulus(0, 0, 64'd0, 1, 0);
        track_occ = 1'b0;
        checkOutput("wrap_retired_count", 64'(retired.size()), 64'd16);
        for (int i = 0; i < retired.size() && i < 16; i++)
            checkOutput("wrap_order", 64'(retired[i]), 64'(i));
`ifdef RCA_WB_BYPASS_EN
        checkOutput("wrap_max_occupancy", 64'(max_occ), 64'd0);
`else
        checkOutput("wrap_max_occupancy", 64'(max_occ), 64'd1);
`endif

        // Flush with a push and an ack in the same cycle.
        retired.delete();
        for (int i = 0; i < 3; i++) applyStimulus(1, 20 + i, mkRd(20 + i), 0, 0);
        checkOutput("flush_pre_occupancy", 64'(occupancy), 64'd3);
        applyStimulus(1, 23, mkRd(23), 1, 1);
        checkOutput("flush_done", 64'(wb_done), 64'd0);
        checkOutput("flush_occupancy", 64'(occupancy), 64'd0);
        checkOutput("flush_retired_count", 64'(retired.size()), 64'd0);
        applyStimulus(0, 0, 64'd0, 0, 0);
        checkOutput("flush_after_done", 64'(wb_done), 64'd0);

        // Spurious ack on an empty buffer.
        applyStimulus(0, 0, 64'd0, 1, 0);
        checkOutput("spurious_occupancy", 64'(occupancy), 64'd0);
        checkOutput("spurious_ready", 64'(result_ready), 64'd1);

        // Reset asserted mid-operation.
        applyStimulus(1, 30, mkRd(30), 0, 0);
        applyStimulus(1, 31, mkRd(31), 0, 0);
        rst = 1'b0;
        applyStimulus(1, 32, mkRd(32), 0, 0);
        checkOutput("midreset_occupancy", 64'(occupancy), 64'd0);
        checkOutput("midreset_done", 64'(wb_done), 64'd0);
        rst = 1'b1;
        applyStimulus(1, 33, mkRd(33), 0, 0);
        checkOutput("post_reset_id", 64'(wb_id), 64'd33);
        checkOutput("post_reset_rd", wb_rd, mkRd(33));
        applyStimulus(0, 0, 64'd0, 1, 0);
        applyStimulus(0, 0, 64'd0, 0, 0);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
